multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Control unit for the multicycle RV32I datapath; successor to the single-cycle main decoder.
//  Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and adds I-type ALU ops and JAL.
//  Adds a memory ready handshake and an illegal-opcode trap.
//  Sits between the instruction register opcode/ALU zero flag and the datapath mux/enable controls.
// PARAMETERS
//  SUPPORT_IALU  1  1: opcode 0010011 is decoded; 0: it traps as illegal
//  SUPPORT_JAL   1  1: opcode 1101111 is decoded; 0: it traps as illegal
//  MEM_HANDSHAKE 1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready is ignored (treated as 1)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  op         in   7  opcode from the instruction register
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  unified memory access complete this cycle
//  PCWrite    out  1  PC register enable = PCUpdate | (Branch & zero)
//  AdrSrc     out  1  0: PC, 1: ALUOut to the memory address
//  MemWrite   out  1  memory write strobe
//  IRWrite    out  1  instruction/OldPC register enable
//  ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1
//  ALUSrcB    out  2  00 rs2, 01 ImmExt, 10 const 4
//  ALUOp      out  2  00 add, 01 sub/compare, 10 funct-decoded
//  ImmSrc     out  2  combinational from op: sw 01, beq 10, jal 11, else 00
//  RegWrite   out  1  register file write enable
//  illegal    out  1  sticky illegal-opcode flag
// BEHAVIOUR
//  Outputs are Moore-decoded from the state register, except:
//   - PCWrite uses zero.
//   - IRWrite, PCUpdate and MemWrite are gated by the effective ready.
//   - ImmSrc is combinational from op.
//  Effective ready: rdy = MEM_HANDSHAKE ? mem_ready : 1.
//  Reset (async, rst_n=0): state=FETCH, illegal=0. All enables are 0 while reset is held.
//   - Reset mid-instruction abandons it. There is no partial writeback after reset.
//  Controls not listed for a state are 0.
//  State table:
//   FETCH:    AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=rdy
//             -> DECODE if rdy, else stay in FETCH
//   DECODE:   SrcA=01, SrcB=01, ALUOp=00 (branch target)
//             -> by op: lw/sw MEMADR; R EXECUTER; I EXECUTEI; beq BEQ; jal JAL; other TRAP
//   MEMADR:   SrcA=10, SrcB=01, ALUOp=00 -> MEMREAD (lw) or MEMWRITE (sw)
//   MEMREAD:  AdrSrc=1, ResultSrc=00 -> MEMWB if rdy, else stay
//   MEMWB:    ResultSrc=01, RegWrite=1 -> FETCH
//   MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=rdy -> FETCH if rdy, else stay
//   EXECUTER: SrcA=10, SrcB=00, ALUOp=10 -> ALUWB
//   EXECUTEI: SrcA=10, SrcB=01, ALUOp=10 -> ALUWB
//   ALUWB:    ResultSrc=00, RegWrite=1 -> FETCH
//   BEQ:      SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH
//   JAL:      SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB
//   TRAP:     illegal=1, all enables 0; stays in TRAP until reset
//  Disabled-parameter opcodes go to TRAP from DECODE.
//  op is sampled only in DECODE and MEMADR. Changes in other states are ignored.
//  Instruction cycle counts with rdy=1:
//   lw 5, sw 4, R/I 4, beq 3, jal 4.
//  Each cycle rdy=0 in a wait state adds one cycle.
//  Unreachable state encodings go to FETCH on the next clock.
//  MemWrite and RegWrite are never 1 in the same cycle.
// TESTING
//  1. Reset: rst_n=0 mid-MEMWB -> RegWrite falls immediately, state=FETCH, illegal=0.
//  2. lw, mem_ready=1 -> states F,D,MA,MR,MWB. RegWrite=1 only in cycle 5 with ResultSrc=01.
//  3. sw, mem_ready low 3 cycles in MEMWRITE -> MemWrite=0 for 3 cycles, then 1 for exactly 1 cycle, then FETCH.
//  4. beq: zero=1 -> PCWrite=1 in cycle 3. zero=0 -> PCWrite=0, next FETCH.
//  5. jal with SUPPORT_JAL=1 -> PCWrite in cycle 3, RegWrite in cycle 4.
//     With SUPPORT_JAL=0 -> TRAP, illegal=1 held for 10 cycles.
//  6. addi (0010011) -> ALUSrcB=01, ALUOp=10 in EXECUTEI.
//     Opcode 0000000 -> illegal=1, no writes.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control unit for the multicycle RV32I datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and traps on unsupported opcodes.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  FETCH    | read instruction at PC, compute PC+4, wait for memory
//  DECODE   | register read, compute branch/jump target into ALUOut
//  MEMADR   | compute load/store address rs1 + imm
//  MEMREAD  | load data from ALUOut address, wait for memory
//  MEMWB    | write loaded data to rd
//  MEMWRITE | store rs2 to ALUOut address, wait for memory
//  EXECUTER | R-type ALU operation rs1 op rs2
//  EXECUTEI | I-type ALU operation rs1 op imm
//  ALUWB    | write ALUOut to rd
//  BEQ      | compare rs1/rs2, take branch target when zero
//  JAL      | load jump target into PC, compute link address OldPC+4
//  TRAP     | illegal opcode seen; frozen until reset
module multicycle_control_fsm #(
    parameter bit SUPPORT_IALU  = 1'b1,
    parameter bit SUPPORT_JAL   = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t state, state_next;
    logic   illegal_q;
    logic   rdy;

    logic   pc_update;
    logic   branch;
    logic   ir_write_s;
    logic   mem_write_s;
    logic   reg_write_s;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:   state_next = S_MEMADR;
                    OP_R:    state_next = S_EXECUTER;
                    OP_I:    state_next = SUPPORT_IALU ? S_EXECUTEI : S_TRAP;
                    OP_BEQ:  state_next = S_BEQ;
                    OP_JAL:  state_next = SUPPORT_JAL ? S_JAL : S_TRAP;
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        case (state)
            S_FETCH: begin
                ResultSrc  = 2'b10;
                ALUSrcB    = 2'b10;
                ir_write_s = rdy;
                pc_update  = rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = rdy;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Enables are forced low while reset is held so nothing is written mid-reset.
    assign PCWrite  = rst_n & (pc_update | (branch & zero));
    assign IRWrite  = rst_n & ir_write_s;
    assign MemWrite = rst_n & mem_write_s;
    assign RegWrite = rst_n & reg_write_s;
    assign illegal  = illegal_q;

endmodule
